snn_lif_array: RTL

Parametrised leaky-integrate-and-fire neuron array, the next-generation spiking core for the TinyTapeout SNN user project. It holds `NUM_NEURONS` independent neurons with per-neuron signed input weights, a global threshold, a shift-based leak and a refractory period, all runtime-programmable through a register-write port. It sits between the `tt_um_*` top-level pin mapping and the input spike pins: `spike_in` comes from `ui_in`, and `spike_out` drives `uo_out`. Cocotb drives it through the same `tb` wrapper style.

---
 rtl/snn_lif_array.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/snn_lif_array.sv
// snn_lif_array: leaky-integrate-and-fire neuron array with programmable weights, threshold,
// shift leak and refractory period. Define SNN_INHIBIT_EN for winner-take-all lateral inhibition.
module snn_lif_array #(
  parameter int NUM_NEURONS = 8,
  parameter int MEM_W       = 8,
  parameter int WEIGHT_W    = 4,
  parameter int REFRAC_W    = 3
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  ena,
  input  logic [NUM_NEURONS-1:0]                                spike_in,
  input  logic                                                  cfg_we,
  input  logic [$clog2(NUM_NEURONS+3)-1:0]                      cfg_addr,
  input  logic [MEM_W-1:0]                                      cfg_data,
  input  logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] mon_sel,
  output logic [NUM_NEURONS-1:0]                                spike_out,
  output logic [MEM_W-1:0]                                      mon_mem,
  output logic [7:0]                                            spike_cnt
);

  localparam int ADDR_W = $clog2(NUM_NEURONS + 3);
  localparam int SEL_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int LEAK_W = $clog2(MEM_W);
  localparam int EXT_W  = MEM_W + 2;
  localparam logic [MEM_W-1:0] THRESH_RST = {1'b1, {(MEM_W-1){1'b0}}};
  localparam logic [MEM_W-1:0] MEM_MAX    = {MEM_W{1'b1}};

  // Configuration registers
  logic [WEIGHT_W-1:0] r_weight [NUM_NEURONS];
  logic [MEM_W-1:0]    r_thresh;
  logic [LEAK_W-1:0]   r_leak;
  logic [REFRAC_W-1:0] r_refrac_per;

  // Neuron state
  logic [MEM_W-1:0]       r_mem        [NUM_NEURONS];
  logic [REFRAC_W-1:0]    r_refrac_cnt [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_spike;
  logic [7:0]             r_spike_cnt;

  // Per-neuron datapath
  logic [MEM_W-1:0]       w_leak_amt [NUM_NEURONS];
  logic [EXT_W-1:0]       w_wext     [NUM_NEURONS];
  logic [EXT_W-1:0]       w_sum      [NUM_NEURONS];
  logic [MEM_W-1:0]       w_integ    [NUM_NEURONS];
  logic [MEM_W-1:0]       w_mem_nxt  [NUM_NEURONS];
  logic [REFRAC_W-1:0]    w_cnt_nxt  [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] w_refrac_act;
  logic [NUM_NEURONS-1:0] w_fire_raw;
  logic [NUM_NEURONS-1:0] w_fire;
  logic [7:0]             w_fire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_weight[i] <= '0;
      end
      r_thresh     <= THRESH_RST;
      r_leak       <= '0;
      r_refrac_per <= REFRAC_W'(2);
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (cfg_addr == ADDR_W'(i)) begin
          r_weight[i] <= cfg_data[WEIGHT_W-1:0];
        end
      end
      if (cfg_addr == ADDR_W'(NUM_NEURONS)) begin
        r_thresh <= cfg_data;
      end
      if (cfg_addr == ADDR_W'(NUM_NEURONS + 1)) begin
        r_leak <= cfg_data[LEAK_W-1:0];
      end
      if (cfg_addr == ADDR_W'(NUM_NEURONS + 2)) begin
        r_refrac_per <= cfg_data[REFRAC_W-1:0];
      end
    end
  end

  // Integrate in MEM_W+2 bits: the top bit flags a negative result, the next one an overflow.
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_leak_amt[i] = (r_leak != '0) ? (r_mem[i] >> r_leak) : '0;
      w_wext[i]     = spike_in[i] ?
                      {{(EXT_W-WEIGHT_W){r_weight[i][WEIGHT_W-1]}}, r_weight[i]} : '0;
      w_sum[i]      = {2'b00, r_mem[i]} - {2'b00, w_leak_amt[i]} + w_wext[i];
      if (w_sum[i][EXT_W-1]) begin
        w_integ[i] = '0;
      end else if (w_sum[i][EXT_W-2]) begin
        w_integ[i] = MEM_MAX;
      end else begin
        w_integ[i] = w_sum[i][MEM_W-1:0];
      end
      w_refrac_act[i] = (r_refrac_cnt[i] != '0);
      w_fire_raw[i]   = !w_refrac_act[i] && (r_thresh != '0) && (w_integ[i] >= r_thresh);
    end
  end

`ifdef SNN_INHIBIT_EN
  // Lowest-index firing neuron wins: isolate the least significant set bit.
  assign w_fire = w_fire_raw & (~w_fire_raw + NUM_NEURONS'(1));
`else
  assign w_fire = w_fire_raw;
`endif

  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_mem_nxt[i] = r_mem[i];
      w_cnt_nxt[i] = r_refrac_cnt[i];
      if (w_refrac_act[i]) begin
        w_cnt_nxt[i] = r_refrac_cnt[i] - REFRAC_W'(1);
        w_mem_nxt[i] = '0;
      end else if (w_fire[i]) begin
        w_cnt_nxt[i] = r_refrac_per;
        w_mem_nxt[i] = '0;
`ifdef SNN_INHIBIT_EN
      end else if (|w_fire_raw) begin
        w_mem_nxt[i] = '0;
`endif
      end else begin
        w_mem_nxt[i] = w_integ[i];
      end
    end
  end

  always_comb begin
    w_fire_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_fire_cnt = w_fire_cnt + {7'd0, w_fire[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_mem[i]        <= '0;
        r_refrac_cnt[i] <= '0;
      end
      r_spike     <= '0;
      r_spike_cnt <= '0;
    end else if (ena) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_mem[i]        <= w_mem_nxt[i];
        r_refrac_cnt[i] <= w_cnt_nxt[i];
      end
      r_spike     <= w_fire;
      r_spike_cnt <= r_spike_cnt + w_fire_cnt;
    end else begin
      r_spike <= '0;
    end
  end

  always_comb begin
    mon_mem = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (mon_sel == SEL_W'(i)) begin
        mon_mem = r_mem[i];
      end
    end
  end

  assign spike_out = r_spike;
  assign spike_cnt = r_spike_cnt;

endmodule
